// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Sequential instruction fetch with a 2-entry show-ahead prefetch
//            buffer, consumer back-pressure and branch redirect/flush.
// Revision : 1.0 - initial release
// ============================================================================
//
// Timing model:
//   The ROM registers its output on the falling edge for the address it sees
//   in that cycle. A word whose address is presented in cycle N is therefore
//   already on rom_data at the posedge that closes cycle N. The in-flight slot
//   is the fetch issued in the current cycle. Its tag is the current fetch_pc.
//   Its word lands in the FIFO at the closing edge. This gives the one-cycle
//   address-to-instr_valid latency.
//
//   A slot is only issued when the FIFO, after this cycle's pop, still has
//   room for the in-flight word. That keeps the buffer from ever overflowing.
// ============================================================================
module fetch_unit #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam logic [1:0] DEPTH = 2'd2;

    // Fetch address register; drives the ROM directly.
    logic [ADDR_WIDTH-1:0] fetch_pc;

    // Prefetch FIFO storage and bookkeeping.
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [ADDR_WIDTH-1:0] fifo_pc   [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic [1:0]            count_next;
    logic [1:0]            room_after_pop;

    // In-flight slot: the fetch issued this cycle and its address tag.
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] tag;

    logic                  pop;
    logic                  push;

    assign rom_addr = fetch_pc;

    // Head of buffer, forced to zero while empty.
    always_comb begin
        instr_valid = (count != 2'd0);
        instr       = '0;
        instr_pc    = '0;
        if (instr_valid) begin
            instr    = fifo_data[rd_ptr];
            instr_pc = fifo_pc[rd_ptr];
        end
    end

    // Issue decision and FIFO occupancy update.
    always_comb begin
        pop            = instr_valid & instr_ready;
        room_after_pop = count - {1'b0, pop};
        inflight       = !redirect && (room_after_pop < DEPTH);
        tag            = fetch_pc;
        push           = inflight;
        count_next     = count + {1'b0, push} - {1'b0, pop};
        if (redirect) begin
            count_next = 2'd0;
        end
    end

    // Fetch PC: load on redirect, advance on every issued slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (inflight) begin
            fetch_pc <= fetch_pc + 1'b1;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            rd_ptr <= rd_ptr ^ pop;
            wr_ptr <= wr_ptr ^ push;
            count  <= count_next;
        end
    end

    // FIFO storage: capture the returning ROM word with its tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
        end else if (push) begin
            fifo_data[wr_ptr] <= rom_data;
            fifo_pc[wr_ptr]   <= tag;
        end
    end

endmodule
`default_nettype wire
